// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the machine-mode CSR unit: CSR addresses, the
// read-modify-write op encoding, WARL masks, mstatus bit positions and small
// helpers for counter address decoding and RMW evaluation.
// ---------------------------------------------------------------------------
package csr_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_e;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;

    // Upper-half counters sit 0x080 above the lower half; the user-mode
    // read-only shadows sit 0x100 above the machine-mode counters.
    localparam logic [11:0] CSR_HI_OFFSET   = 12'h080;
    localparam logic [11:0] CSR_USER_OFFSET = 12'h100;

    // mstatus layout
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    // WARL masks
    localparam logic [31:0] MIE_WMASK   = 32'h0000_0888;
    localparam logic [31:0] ALIGN4_MASK = 32'hFFFF_FFFC;

    // Counter index 0 is mcycle (0xB00), index 1 is minstret (0xB02) and
    // index 2+k is mhpmcounter(3+k) (0xB03+k): index i>=1 maps to 0xB01+i.
    function automatic logic [11:0] cnt_addr(input int idx);
        return (idx == 0) ? CSR_MCYCLE : CSR_MCYCLE + 12'(idx + 1);
    endfunction

    // mcountinhibit writable bits: CY (0), IR (2) and one per event counter.
    function automatic logic [31:0] cinh_mask(input int num_hpm);
        logic [31:0] m;
        m = 32'h0000_0005;
        for (int k = 0; k < num_hpm; k++) begin
            m[3+k] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [31:0] csr_rmw(input csr_op_e op,
                                            input logic [31:0] old,
                                            input logic [31:0] d);
        case (op)
            OP_WRITE: return d;
            OP_SET:   return old | d;
            OP_CLEAR: return old & ~d;
            default:  return old;
        endcase
    endfunction

endpackage

// File: rtl/csr_if.sv
// ---------------------------------------------------------------------------
// csr_if
// Execute-unit to CSR-unit access port.
//   req     master->slave  access strobe
//   op      master->slave  read / write / set / clear
//   addr    master->slave  12-bit CSR address
//   wdata   master->slave  operand (rs1 or zimm)
//   rdata   slave->master  old CSR value, combinational
//   illegal slave->master  unknown address or modifying a read-only CSR
// ---------------------------------------------------------------------------
interface csr_if;
    import csr_pkg::*;

    logic        req;
    csr_op_e     op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        illegal;

    modport master (output req, op, addr, wdata, input rdata, illegal);
    modport slave  (input req, op, addr, wdata, output rdata, illegal);

endinterface

// File: rtl/csr_counter.sv
// ---------------------------------------------------------------------------
// csr_counter
// One CNT_W-bit performance counter with split 32-bit write halves.
//   clk, rst   clock, synchronous active-high reset
//   inc        count event this cycle
//   inhibit    freeze counting (writes still land)
//   we_lo      replace bits [31:0] with wdata
//   we_hi      replace bits [CNT_W-1:32] with wdata
//   wdata      write data
//   value      current count
// A write to either half suppresses the increment for that cycle.
// ---------------------------------------------------------------------------
module csr_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             inhibit,
    input  logic             we_lo,
    input  logic             we_hi,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] value
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (we_lo) begin
            value[31:0] <= wdata;
        end else if (we_hi) begin
            value[CNT_W-1:32] <= wdata[CNT_W-33:0];
        end else if (inc && !inhibit) begin
            value <= value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/csr_unit.sv
// ---------------------------------------------------------------------------
// csr_unit
// Machine-mode CSR unit: CSRRW/CSRRS/CSRRC read-modify-write with WARL
// masking, trap entry / MRET stacking of mstatus, 64-bit style counters with
// inhibit control and the interrupt request for the CLINT.
//   clk, rst            clock, synchronous active-high reset
//   exu                 csr_if slave: access port from the execute unit
//   trap_i              trap entry strobe (cause/pc alongside)
//   mret_i              MRET retire strobe
//   instret_i           one instruction retired
//   hpm_event_i         per event-counter increment pulse
//   irq_ext/timer/sw_i  level interrupt sources, visible through mip
//   mtvec_o, mepc_o     register values
//   mstatus_mie_o       global interrupt enable
//   irq_req_o           enabled interrupt pending and mstatus.MIE set
// Priority of same-cycle updates: rst > trap_i > mret_i > exu write.
// ---------------------------------------------------------------------------
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID   = 32'd0,
    parameter logic [31:0] MTVEC_RST = 32'h0,
    parameter int          NUM_HPM   = 2,    // 0..8
    parameter int          CNT_W     = 64    // 33..64
) (
    input  logic                                clk,
    input  logic                                rst,
    csr_if.slave                                exu,
    input  logic                                trap_i,
    input  logic [31:0]                         trap_cause_i,
    input  logic [31:0]                         trap_pc_i,
    input  logic                                mret_i,
    input  logic                                instret_i,
    input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event_i,
    input  logic                                irq_ext_i,
    input  logic                                irq_timer_i,
    input  logic                                irq_sw_i,
    output logic [31:0]                         mtvec_o,
    output logic [31:0]                         mepc_o,
    output logic                                mstatus_mie_o,
    output logic                                irq_req_o
);

    localparam int          NUM_CNT    = 2 + NUM_HPM;
    localparam logic [31:0] CINH_WMASK = cinh_mask(NUM_HPM);

    // Architectural state
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mie_reg;
    logic [31:0] mtvec_reg;
    logic [31:0] mscratch;
    logic [31:0] mepc_reg;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] mcountinhibit;

    logic [CNT_W-1:0]   cnt_value [NUM_CNT];
    logic [63:0]        cnt_ext   [NUM_CNT];
    logic [NUM_CNT-1:0] cnt_we_lo;
    logic [NUM_CNT-1:0] cnt_we_hi;
    logic [NUM_CNT-1:0] cnt_inc;
    logic [NUM_CNT-1:0] cnt_inhibit;

    // Access decode
    logic [31:0] mstatus_rd;
    logic [31:0] mip_rd;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        known;
    logic        read_only;
    logic        modifies;
    logic        illegal;
    logic        wr_en;

    // MPP is hardwired to machine mode (11).
    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
    assign mip_rd     = {20'b0, irq_ext_i, 3'b0, irq_timer_i, 3'b0, irq_sw_i, 3'b0};

    // NOTE: every always_comb output gets a default before the case/loop so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        known     = 1'b1;
        read_only = 1'b0;
        old_val   = '0;
        case (exu.addr)
            CSR_MSTATUS:       old_val = mstatus_rd;
            CSR_MIE:           old_val = mie_reg;
            CSR_MTVEC:         old_val = mtvec_reg;
            CSR_MCOUNTINHIBIT: old_val = mcountinhibit;
            CSR_MSCRATCH:      old_val = mscratch;
            CSR_MEPC:          old_val = mepc_reg;
            CSR_MCAUSE:        old_val = mcause;
            CSR_MTVAL:         old_val = mtval;
            CSR_MIP: begin
                old_val   = mip_rd;
                read_only = 1'b1;
            end
            CSR_MHARTID: begin
                old_val   = HART_ID;
                read_only = 1'b1;
            end
            default: known = 1'b0;
        endcase
        for (int i = 0; i < NUM_CNT; i++) begin
            if (exu.addr == cnt_addr(i)) begin
                known   = 1'b1;
                old_val = cnt_ext[i][31:0];
            end
            if (exu.addr == (cnt_addr(i) | CSR_HI_OFFSET)) begin
                known   = 1'b1;
                old_val = cnt_ext[i][63:32];
            end
            // Only cycle/instret have user-mode shadows.
            if (i < 2 && exu.addr == cnt_addr(i) + CSR_USER_OFFSET) begin
                known     = 1'b1;
                read_only = 1'b1;
                old_val   = cnt_ext[i][31:0];
            end
            if (i < 2 && exu.addr == (cnt_addr(i) | CSR_HI_OFFSET) + CSR_USER_OFFSET) begin
                known     = 1'b1;
                read_only = 1'b1;
                old_val   = cnt_ext[i][63:32];
            end
        end
    end

    // Set/clear with a zero operand is a pure read, even on read-only CSRs.
    assign modifies = (exu.op == OP_WRITE) ||
                      ((exu.op == OP_SET || exu.op == OP_CLEAR) && exu.wdata != '0);
    assign illegal  = exu.req && (!known || (read_only && modifies));
    assign wr_en    = exu.req && known && !read_only && modifies;
    assign new_val  = csr_rmw(exu.op, old_val, exu.wdata);

    assign exu.illegal = illegal;
    assign exu.rdata   = illegal ? '0 : old_val;

    // Counters: index 0 mcycle, 1 minstret, 2+k mhpmcounter(3+k)
    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        assign cnt_we_lo[g]   = wr_en && (exu.addr == cnt_addr(g));
        assign cnt_we_hi[g]   = wr_en && (exu.addr == (cnt_addr(g) | CSR_HI_OFFSET));
        // mcountinhibit bit 1 (time) is absent, so index i>=1 uses bit i+1.
        assign cnt_inhibit[g] = mcountinhibit[(g == 0) ? 0 : g + 1];
        assign cnt_ext[g]     = 64'(cnt_value[g]);

        if (g == 0) begin : g_cycle
            assign cnt_inc[g] = 1'b1;
        end else if (g == 1) begin : g_instret
            assign cnt_inc[g] = instret_i;
        end else begin : g_hpm
            assign cnt_inc[g] = hpm_event_i[g-2];
        end

        csr_counter #(
            .CNT_W (CNT_W)
        ) u_counter (
            .clk     (clk),
            .rst     (rst),
            .inc     (cnt_inc[g]),
            .inhibit (cnt_inhibit[g]),
            .we_lo   (cnt_we_lo[g]),
            .we_hi   (cnt_we_hi[g]),
            .wdata   (new_val),
            .value   (cnt_value[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie   <= 1'b0;
            mstatus_mpie  <= 1'b0;
            mie_reg       <= '0;
            mtvec_reg     <= MTVEC_RST & ALIGN4_MASK;
            mscratch      <= '0;
            mepc_reg      <= '0;
            mcause        <= '0;
            mtval         <= '0;
            mcountinhibit <= '0;
        end else begin
            if (trap_i) begin
                mepc_reg     <= trap_pc_i & ALIGN4_MASK;
                mcause       <= trap_cause_i;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret_i) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end

            // Exu writes yield only on the registers trap/MRET touch.
            if (wr_en) begin
                case (exu.addr)
                    CSR_MSTATUS: begin
                        if (!trap_i && !mret_i) begin
                            mstatus_mie  <= new_val[MSTATUS_MIE_BIT];
                            mstatus_mpie <= new_val[MSTATUS_MPIE_BIT];
                        end
                    end
                    CSR_MIE:           mie_reg   <= new_val & MIE_WMASK;
                    CSR_MTVEC:         mtvec_reg <= new_val & ALIGN4_MASK;
                    CSR_MSCRATCH:      mscratch  <= new_val;
                    CSR_MEPC: begin
                        if (!trap_i) mepc_reg <= new_val & ALIGN4_MASK;
                    end
                    CSR_MCAUSE: begin
                        if (!trap_i) mcause <= new_val;
                    end
                    CSR_MTVAL:         mtval         <= new_val;
                    CSR_MCOUNTINHIBIT: mcountinhibit <= new_val & CINH_WMASK;
                    default: ;
                endcase
            end
        end
    end

    assign mtvec_o       = mtvec_reg;
    assign mepc_o        = mepc_reg;
    assign mstatus_mie_o = mstatus_mie;
    assign irq_req_o     = (|(mip_rd & mie_reg)) & mstatus_mie;

endmodule

// File: tb/tb_csr_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_unit
// Directed self-checking bench for csr_unit. Inputs change on the falling
// edge; combinational outputs are sampled 1 time unit later, registered
// effects are checked after the following falling edge.
// ---------------------------------------------------------------------------
module tb_csr_unit;
    import csr_pkg::*;

    logic        clk;
    logic        rst;
    logic        trap_i;
    logic [31:0] trap_cause_i;
    logic [31:0] trap_pc_i;
    logic        mret_i;
    logic        instret_i;
    logic [1:0]  hpm_event_i;
    logic        irq_ext_i;
    logic        irq_timer_i;
    logic        irq_sw_i;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mstatus_mie_o;
    logic        irq_req_o;

    csr_if exu ();

    csr_unit #(
        .HART_ID   (32'd5),
        .MTVEC_RST (32'h0000_0203),
        .NUM_HPM   (2),
        .CNT_W     (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .exu           (exu),
        .trap_i        (trap_i),
        .trap_cause_i  (trap_cause_i),
        .trap_pc_i     (trap_pc_i),
        .mret_i        (mret_i),
        .instret_i     (instret_i),
        .hpm_event_i   (hpm_event_i),
        .irq_ext_i     (irq_ext_i),
        .irq_timer_i   (irq_timer_i),
        .irq_sw_i      (irq_sw_i),
        .mtvec_o       (mtvec_o),
        .mepc_o        (mepc_o),
        .mstatus_mie_o (mstatus_mie_o),
        .irq_req_o     (irq_req_o)
    );

    int          tests_run;
    int          tests_failed;
    logic [31:0] rd;
    logic        ill;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called on a falling edge: presents one access for one cycle, samples
    // the combinational response, and returns on the next falling edge.
    task automatic access(input csr_op_e op, input logic [11:0] a,
                          input logic [31:0] d,
                          output logic [31:0] rdata, output logic illegal);
        exu.req   = 1'b1;
        exu.op    = op;
        exu.addr  = a;
        exu.wdata = d;
        #1;
        rdata   = exu.rdata;
        illegal = exu.illegal;
        @(negedge clk);
        exu.req   = 1'b0;
        exu.op    = OP_READ;
        exu.wdata = '0;
    endtask

    task automatic pulse_trap(input logic [31:0] pc, input logic [31:0] cause);
        trap_i       = 1'b1;
        trap_pc_i    = pc;
        trap_cause_i = cause;
        @(negedge clk);
        trap_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        access(OP_READ, CSR_MCYCLE, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_mcycle: got %h want %h", rd, 32'h0); end
        tests_run++;
        if (mtvec_o !== 32'h0000_0200) begin tests_failed++; $display("FAIL reset_mtvec: got %h want %h", mtvec_o, 32'h200); end
        tests_run++;
        if (mepc_o !== 32'h0 || mstatus_mie_o !== 1'b0 || irq_req_o !== 1'b0) begin
            tests_failed++; $display("FAIL reset_outputs: mepc %h mie %b irq %b want 0", mepc_o, mstatus_mie_o, irq_req_o);
        end
        access(OP_READ, CSR_MSTATUS, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h0000_1800) begin tests_failed++; $display("FAIL reset_mstatus: got %h want %h", rd, 32'h1800); end
        access(OP_READ, CSR_MHARTID, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'd5 || ill !== 1'b0) begin tests_failed++; $display("FAIL reset_mhartid: got %h/%b want 5/0", rd, ill); end
    endtask

    task automatic test_mie_rmw();
        access(OP_SET, CSR_MIE, 32'h888, rd, ill);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL mie_set_old: got %h want %h", rd, 32'h0); end
        access(OP_READ, CSR_MIE, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h888) begin tests_failed++; $display("FAIL mie_set_new: got %h want %h", rd, 32'h888); end
        access(OP_WRITE, CSR_MIE, 32'hFFFF_FFFF, rd, ill);
        tests_run++;
        if (rd !== 32'h888) begin tests_failed++; $display("FAIL mie_write_old: got %h want %h", rd, 32'h888); end
        access(OP_READ, CSR_MIE, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h888) begin tests_failed++; $display("FAIL mie_warl: got %h want %h", rd, 32'h888); end
        access(OP_CLEAR, CSR_MIE, 32'h808, rd, ill);
        access(OP_READ, CSR_MIE, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h080) begin tests_failed++; $display("FAIL mie_clear: got %h want %h", rd, 32'h080); end
    endtask

    task automatic test_mtvec_hartid();
        access(OP_WRITE, CSR_MTVEC, 32'h8000_0103, rd, ill);
        access(OP_READ, CSR_MTVEC, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h8000_0100 || mtvec_o !== 32'h8000_0100) begin
            tests_failed++; $display("FAIL mtvec_warl: got %h/%h want %h", rd, mtvec_o, 32'h8000_0100);
        end
        access(OP_WRITE, CSR_MHARTID, 32'h1, rd, ill);
        tests_run++;
        if (ill !== 1'b1 || rd !== 32'h0) begin tests_failed++; $display("FAIL hartid_write: illegal %b rdata %h want 1/0", ill, rd); end
        access(OP_READ, CSR_MHARTID, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'd5 || ill !== 1'b0) begin tests_failed++; $display("FAIL hartid_after: got %h/%b want 5/0", rd, ill); end
        access(OP_READ, 12'h7C0, 32'h0, rd, ill);
        tests_run++;
        if (ill !== 1'b1 || rd !== 32'h0) begin tests_failed++; $display("FAIL unknown_addr: illegal %b rdata %h want 1/0", ill, rd); end
        access(OP_SET, CSR_MIP, 32'h0, rd, ill);
        tests_run++;
        if (ill !== 1'b0) begin tests_failed++; $display("FAIL mip_pure_read: illegal %b want 0", ill); end
    endtask

    task automatic test_trap_mret();
        access(OP_SET, CSR_MSTATUS, 32'h8, rd, ill);
        tests_run++;
        if (mstatus_mie_o !== 1'b1) begin tests_failed++; $display("FAIL mie_set: got %b want 1", mstatus_mie_o); end
        pulse_trap(32'h0000_1002, 32'h8000_0007);
        tests_run++;
        if (mepc_o !== 32'h0000_1000) begin tests_failed++; $display("FAIL trap_mepc: got %h want %h", mepc_o, 32'h1000); end
        access(OP_READ, CSR_MCAUSE, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h8000_0007) begin tests_failed++; $display("FAIL trap_mcause: got %h want %h", rd, 32'h8000_0007); end
        access(OP_READ, CSR_MSTATUS, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h0000_1880) begin tests_failed++; $display("FAIL trap_mstatus: got %h want %h", rd, 32'h1880); end
        mret_i = 1'b1;
        @(negedge clk);
        mret_i = 1'b0;
        access(OP_READ, CSR_MSTATUS, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h0000_1888) begin tests_failed++; $display("FAIL mret_mstatus: got %h want %h", rd, 32'h1888); end
    endtask

    task automatic test_trap_priority();
        trap_i = 1'b1; trap_pc_i = 32'h0000_2000; trap_cause_i = 32'h2;
        access(OP_WRITE, CSR_MSTATUS, 32'h0, rd, ill);
        trap_i = 1'b0;
        access(OP_READ, CSR_MSTATUS, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h0000_1880) begin tests_failed++; $display("FAIL prio_mstatus: got %h want %h", rd, 32'h1880); end
        trap_i = 1'b1; trap_pc_i = 32'h0000_3004; trap_cause_i = 32'h3;
        access(OP_WRITE, CSR_MSCRATCH, 32'hDEAD_BEEF, rd, ill);
        trap_i = 1'b0;
        access(OP_READ, CSR_MSCRATCH, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL prio_mscratch: got %h want %h", rd, 32'hDEAD_BEEF); end
        access(OP_READ, CSR_MSTATUS, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h0000_1800) begin tests_failed++; $display("FAIL prio_mstatus2: got %h want %h", rd, 32'h1800); end
        trap_i = 1'b1; trap_pc_i = 32'h0000_4000; trap_cause_i = 32'h4;
        access(OP_WRITE, CSR_MEPC, 32'h0000_5554, rd, ill);
        trap_i = 1'b0;
        tests_run++;
        if (mepc_o !== 32'h0000_4000) begin tests_failed++; $display("FAIL prio_mepc: got %h want %h", mepc_o, 32'h4000); end
    endtask

    task automatic test_mcycle();
        access(OP_WRITE, CSR_MCYCLE, 32'hFFFF_FFFF, rd, ill);
        repeat (2) @(negedge clk);
        access(OP_READ, CSR_MCYCLE, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h1) begin tests_failed++; $display("FAIL mcycle_lo: got %h want %h", rd, 32'h1); end
        access(OP_READ, CSR_MCYCLE | CSR_HI_OFFSET, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h1) begin tests_failed++; $display("FAIL mcycle_hi: got %h want %h", rd, 32'h1); end
        // The edge that sets the inhibit bit still counts (3 -> 4).
        access(OP_SET, CSR_MCOUNTINHIBIT, 32'h1, rd, ill);
        repeat (3) @(negedge clk);
        access(OP_READ, CSR_MCYCLE, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h4) begin tests_failed++; $display("FAIL mcycle_frozen: got %h want %h", rd, 32'h4); end
        access(OP_WRITE, CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF, rd, ill);
        access(OP_READ, CSR_MCOUNTINHIBIT, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h0000_001D) begin tests_failed++; $display("FAIL cinh_warl: got %h want %h", rd, 32'h1D); end
        access(OP_WRITE, CSR_MCOUNTINHIBIT, 32'h1, rd, ill);
    endtask

    task automatic test_counters_wrap();
        access(OP_WRITE, CSR_MINSTRET, 32'h5, rd, ill);
        instret_i = 1'b1;
        repeat (3) @(negedge clk);
        instret_i = 1'b0;
        access(OP_READ, CSR_INSTRET, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h8 || ill !== 1'b0) begin tests_failed++; $display("FAIL instret: got %h/%b want 8/0", rd, ill); end
        access(OP_WRITE, CSR_CYCLE, 32'h1, rd, ill);
        tests_run++;
        if (ill !== 1'b1) begin tests_failed++; $display("FAIL user_cycle_write: illegal %b want 1", ill); end
        access(OP_WRITE, CSR_MHPMCOUNTER3 | CSR_HI_OFFSET, 32'hFFFF_FFFF, rd, ill);
        access(OP_WRITE, CSR_MHPMCOUNTER3, 32'hFFFF_FFFF, rd, ill);
        hpm_event_i = 2'b01;
        @(negedge clk);
        hpm_event_i = 2'b00;
        access(OP_READ, CSR_MHPMCOUNTER3, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL hpm3_wrap_lo: got %h want %h", rd, 32'h0); end
        access(OP_READ, CSR_MHPMCOUNTER3 | CSR_HI_OFFSET, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL hpm3_wrap_hi: got %h want %h", rd, 32'h0); end
        access(OP_READ, CSR_MHPMCOUNTER3 + 12'h1, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL hpm4_idle: got %h want %h", rd, 32'h0); end
    endtask

    task automatic test_irq();
        access(OP_WRITE, CSR_MIE, 32'h80, rd, ill);
        access(OP_WRITE, CSR_MSTATUS, 32'h8, rd, ill);
        irq_timer_i = 1'b1;
        #1;
        tests_run++;
        if (irq_req_o !== 1'b1) begin tests_failed++; $display("FAIL irq_on: got %b want 1", irq_req_o); end
        access(OP_READ, CSR_MIP, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h80) begin tests_failed++; $display("FAIL mip_read: got %h want %h", rd, 32'h80); end
        access(OP_CLEAR, CSR_MSTATUS, 32'h8, rd, ill);
        tests_run++;
        if (irq_req_o !== 1'b0) begin tests_failed++; $display("FAIL irq_mie_clear: got %b want 0", irq_req_o); end
        access(OP_SET, CSR_MSTATUS, 32'h8, rd, ill);
        tests_run++;
        if (irq_req_o !== 1'b1) begin tests_failed++; $display("FAIL irq_reenable: got %b want 1", irq_req_o); end
        pulse_trap(32'h0000_0800, 32'h8000_0007);
        tests_run++;
        if (irq_req_o !== 1'b0) begin tests_failed++; $display("FAIL irq_after_trap: got %b want 0", irq_req_o); end
        irq_timer_i = 1'b0;
    endtask

    task automatic test_reset_midrun();
        access(OP_WRITE, CSR_MCOUNTINHIBIT, 32'h0, rd, ill);
        access(OP_WRITE, CSR_MSCRATCH, 32'h0000_1234, rd, ill);
        access(OP_SET, CSR_MSTATUS, 32'h8, rd, ill);
        repeat (4) @(negedge clk);
        // Reset together with a trap and an exu write: both are discarded.
        rst = 1'b1;
        trap_i = 1'b1; trap_pc_i = 32'h0000_7000; trap_cause_i = 32'h5;
        exu.req = 1'b1; exu.op = OP_WRITE; exu.addr = CSR_MSCRATCH; exu.wdata = 32'h5;
        @(negedge clk);
        rst = 1'b0; trap_i = 1'b0; exu.req = 1'b0; exu.op = OP_READ; exu.wdata = '0;
        access(OP_READ, CSR_MCYCLE, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL midrst_mcycle: got %h want %h", rd, 32'h0); end
        tests_run++;
        if (mtvec_o !== 32'h0000_0200 || mepc_o !== 32'h0 || mstatus_mie_o !== 1'b0 || irq_req_o !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_outputs: mtvec %h mepc %h mie %b irq %b", mtvec_o, mepc_o, mstatus_mie_o, irq_req_o);
        end
        access(OP_READ, CSR_MSCRATCH, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL midrst_mscratch: got %h want %h", rd, 32'h0); end
        access(OP_READ, CSR_MSTATUS, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h0000_1800) begin tests_failed++; $display("FAIL midrst_mstatus: got %h want %h", rd, 32'h1800); end
        access(OP_READ, CSR_MIE, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL midrst_mie: got %h want %h", rd, 32'h0); end
        access(OP_READ, CSR_MINSTRET, 32'h0, rd, ill);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL midrst_minstret: got %h want %h", rd, 32'h0); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        trap_i       = 1'b0;
        trap_cause_i = '0;
        trap_pc_i    = '0;
        mret_i       = 1'b0;
        instret_i    = 1'b0;
        hpm_event_i  = '0;
        irq_ext_i    = 1'b0;
        irq_timer_i  = 1'b0;
        irq_sw_i     = 1'b0;
        exu.req      = 1'b0;
        exu.op       = OP_READ;
        exu.addr     = '0;
        exu.wdata    = '0;

        test_reset();
        test_mie_rmw();
        test_mtvec_hartid();
        test_trap_mret();
        test_trap_priority();
        test_mcycle();
        test_counters_wrap();
        test_irq();
        test_reset_midrun();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
